tt_sampler: RTL and testbench
=============================

// Module: tt_sampler
// PURPOSE
//   Recovers the truth table of a generated combinational netlist: sweeps every input vector,
//   waits for settling, samples each output and streams one truth-table word per output.
//   Read-side counterpart of the table-to-gates generator; sits in the equivalence-check
//   harness between the netlist under test and the dataset label checker.
// PARAMETERS
//   N_IN   3  number of netlist inputs x0..x(N_IN-1); 1..8
//   N_OUT  2  number of netlist outputs f0..f(N_OUT-1); 1..16
//   SETTLE 1  cycles dut_x is held before sampling; >=1
// PORTS
//   clk       in   1           single clock, rising edge
//   rst_n     in   1           asynchronous, active-low reset
//   start     in   1           one-cycle request to begin a sweep
//   busy      out  1           high from accepted start until the done pulse (inclusive)
//   dut_x     out  N_IN        input vector driven to netlist; dut_x[k] = x_k
//   dut_f     in   N_OUT       netlist outputs; dut_f[j] = f_j
//   tt_valid  out  1           tt_data/tt_idx hold a table word
//   tt_ready  in   1           consumer accepts the word on valid&ready
//   tt_idx    out  clog2(N_OUT) output index j of current word
//   tt_data   out  2**N_IN     truth table of f_j; bit p = f_j at pattern p
//   done      out  1           one-cycle pulse after last word accepted
// BEHAVIOUR
//   Reset (async assert, sync release): state IDLE; every output 0; tables cleared.
//   Pattern mapping: x0 is MSB of pattern p: dut_x[k] = p[N_IN-1-k].
//   FSM: IDLE -> APPLY -> SAMPLE -> (APPLY | STREAM) -> DONE -> IDLE.
//   IDLE: start=1 accepted -> p=0, busy=1, next APPLY. start while busy ignored, no queueing.
//   APPLY: dut_x=map(p), held SETTLE cycles (settle counter), then SAMPLE.
//   SAMPLE: dut_x unchanged; table[j][p] <= dut_f[j] for all j.
//     p==2**N_IN-1 -> STREAM with j=0; else p++ -> APPLY.
//   STREAM: tt_valid=1, tt_idx=j, tt_data=table[j]. valid&ready: j++; last j -> DONE.
//     tt_valid must not drop and tt_idx/tt_data stay stable while tt_ready=0.
//     Registered outputs: new word visible the cycle after acceptance (1 word / 2 cycles max ok;
//     back-to-back 1 word/cycle preferred, both legal).
//   DONE: done=1 for exactly one cycle, busy=1 that cycle, dut_x returns to 0, -> IDLE.
//   Latency: start at cycle 0 -> first tt_valid at cycle 1 + 2**N_IN*(SETTLE+1).
//   Counters: p width N_IN, wraps never (terminal compare); settle counter width clog2(SETTLE+1).
//   start same cycle as done: ignored (not IDLE yet).
//   Reset mid-sweep or mid-stream: immediate abort, all outputs 0, partial tables discarded.
//   dut_f is sampled only in SAMPLE; glitches during APPLY have no effect.
// STRUCTURE
//   Package tt_pkg: state enum {IDLE,APPLY,SAMPLE,STREAM,DONE}; localparam function
//     tt_width(n)=2**n; pattern-to-vector mapping function map_pattern().
//   Sub-module tt_pattern_gen: pattern counter + settle counter; outputs dut_x, sample_en, last.
//   Top: FSM, N_OUT x 2**N_IN table register file, stream mux.
// TESTING
//   Netlist model f0=x2|x1 (pattern order x0x1x2), f1=x0|x1, SETTLE=1, ready=1 -> words
//     (idx0,0xEE),(idx1,0xFC); first tt_valid at cycle 17; done 1 cycle after last.
//   Same model, tt_ready held 0 for 5 cycles on word 0 -> tt_valid, tt_idx=0, tt_data=0xEE
//     stable throughout; no word lost or duplicated.
//   start pulsed again at cycles 3 and 10 of a sweep -> ignored; single sweep, single done.
//   rst_n low during SAMPLE of p=4 -> all outputs 0 immediately; new start -> 0xEE/0xFC again.
//   SETTLE=3, model delays dut_f by 2 cycles -> tables still 0xEE/0xFC; latency 1+8*4=33.
//   Constant-0 netlist, N_IN=4, N_OUT=1 -> one word 0x0000, idx 0, then done.

Source files
------------

// File: rtl/tt_pkg.sv
// Shared types and helpers for the truth-table sampler.
//   tt_state_e   : sweep/stream FSM states
//   tt_width(n)  : truth-table width for n inputs (2**n)
//   map_pattern  : bit k of the netlist input vector for pattern p.
//                  x0 is the MSB of the pattern, so dut_x[k] = p[n-1-k].
package tt_pkg;

  localparam int MAX_IN = 8;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SAMPLE,
    STREAM,
    DONE
  } tt_state_e;

  function automatic int tt_width(input int n);
    return 1 << n;
  endfunction

  function automatic logic map_pattern(input logic [MAX_IN-1:0] p, input int n, input int k);
    logic bit_v;
    bit_v = 1'b0;
    if (k < n) begin
      bit_v = p[3'(n - 1 - k)];
    end
    return bit_v;
  endfunction

endpackage

// File: rtl/tt_sampler_if.sv
// Control and table-word stream bundle of the truth-table sampler.
//   start    : request to begin a sweep (consumer -> sampler)
//   busy     : sweep/stream in progress, including the done cycle
//   done     : one-cycle pulse after the last word is accepted
//   tt_valid : tt_idx/tt_data hold a table word
//   tt_ready : consumer accepts the word on valid & ready
//   tt_idx   : output index j of the current word
//   tt_data  : truth table of f_j, bit p = f_j at pattern p
// master = sampler side, slave = consumer side.
interface tt_sampler_if #(
  parameter int N_IN  = 3,
  parameter int N_OUT = 2
);
  localparam int TW    = tt_pkg::tt_width(N_IN);
  localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  logic             start;
  logic             busy;
  logic             done;
  logic             tt_valid;
  logic             tt_ready;
  logic [IDX_W-1:0] tt_idx;
  logic [TW-1:0]    tt_data;

  modport master (
    input  start, tt_ready,
    output busy, done, tt_valid, tt_idx, tt_data
  );

  modport slave (
    output start, tt_ready,
    input  busy, done, tt_valid, tt_idx, tt_data
  );

endinterface

// File: rtl/tt_pattern_gen.sv
// Pattern and settle counters of the truth-table sampler.
//   clk, rst_n   : clock, asynchronous active-low reset
//   clr_i        : restart at pattern 0 (sweep accepted)
//   apply_i      : FSM is in APPLY, settle counter runs
//   advance_i    : step to the next pattern (leaving SAMPLE)
//   drive_i      : drive the mapped pattern onto dut_x (else 0)
//   dut_x_o      : netlist input vector
//   sample_en_o  : last settle cycle of APPLY, SAMPLE comes next
//   last_o       : current pattern is the final one
//   p_o          : current pattern index
module tt_pattern_gen
  import tt_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr_i,
  input  logic            apply_i,
  input  logic            advance_i,
  input  logic            drive_i,
  output logic [N_IN-1:0] dut_x_o,
  output logic            sample_en_o,
  output logic            last_o,
  output logic [N_IN-1:0] p_o
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
  localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [N_IN-1:0] P_LAST      = '1;

  logic [N_IN-1:0] p_q, p_d;
  logic [SW-1:0]   settle_q, settle_d;

  assign sample_en_o = apply_i && (settle_q == SETTLE_LAST);
  assign last_o      = (p_q == P_LAST);
  assign p_o         = p_q;

  always_comb begin
    p_d      = p_q;
    settle_d = settle_q;
    if (clr_i) begin
      p_d      = '0;
      settle_d = '0;
    end else begin
      if (apply_i) begin
        // Counter rearms itself on the way out so the next APPLY starts at 0.
        settle_d = sample_en_o ? '0 : settle_q + 1'b1;
      end
      // Terminal compare in the FSM keeps p from ever wrapping.
      if (advance_i) begin
        p_d = p_q + 1'b1;
      end
    end
  end

  always_comb begin
    dut_x_o = '0;
    if (drive_i) begin
      for (int k = 0; k < N_IN; k++) begin
        dut_x_o[k] = map_pattern(MAX_IN'(p_q), N_IN, k);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q      <= '0;
      settle_q <= '0;
    end else begin
      p_q      <= p_d;
      settle_q <= settle_d;
    end
  end

endmodule

// File: rtl/tt_sampler.sv
// Truth-table sampler: sweeps every input vector of a combinational
// netlist, waits SETTLE cycles, samples all outputs, then streams one
// truth-table word per output.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : start/busy/done and tt_valid/tt_ready/tt_idx/tt_data stream
//   dut_x      : input vector driven to the netlist (dut_x[k] = x_k)
//   dut_f      : netlist outputs (dut_f[j] = f_j)
module tt_sampler
  import tt_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int N_OUT  = 2,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  tt_sampler_if.master     bus,
  output logic [N_IN-1:0]  dut_x,
  input  logic [N_OUT-1:0] dut_f
);

  localparam int TW    = tt_width(N_IN);
  localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [IDX_W-1:0] J_LAST = IDX_W'(N_OUT - 1);

  tt_state_e        state_q, state_d;
  logic [IDX_W-1:0] j_q, j_d;
  logic [TW-1:0]    table_q [N_OUT];

  logic            clr;
  logic            advance;
  logic            sample_en;
  logic            last;
  logic [N_IN-1:0] p;

  tt_pattern_gen #(
    .N_IN   (N_IN),
    .SETTLE (SETTLE)
  ) u_pattern_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (clr),
    .apply_i     (state_q == APPLY),
    .advance_i   (advance),
    .drive_i     ((state_q == APPLY) || (state_q == SAMPLE)),
    .dut_x_o     (dut_x),
    .sample_en_o (sample_en),
    .last_o      (last),
    .p_o         (p)
  );

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    clr     = 1'b0;
    advance = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          clr     = 1'b1;
          state_d = APPLY;
        end
      end
      APPLY: begin
        if (sample_en) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        if (last) begin
          j_d     = '0;
          state_d = STREAM;
        end else begin
          advance = 1'b1;
          state_d = APPLY;
        end
      end
      STREAM: begin
        if (bus.tt_ready) begin
          if (j_q == J_LAST) begin
            state_d = DONE;
          end else begin
            j_d = j_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
    end
  end

  // dut_f is only looked at here, so glitches while settling are harmless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < N_OUT; j++) begin
        table_q[j] <= '0;
      end
    end else if (state_q == SAMPLE) begin
      for (int j = 0; j < N_OUT; j++) begin
        table_q[j][p] <= dut_f[j];
      end
    end
  end

  // Word select by compare rather than indexing keeps N_OUT=1 legal.
  always_comb begin
    bus.tt_data = '0;
    if (state_q == STREAM) begin
      for (int j = 0; j < N_OUT; j++) begin
        if (j_q == IDX_W'(j)) begin
          bus.tt_data = table_q[j];
        end
      end
    end
  end

  assign bus.tt_valid = (state_q == STREAM);
  assign bus.tt_idx   = (state_q == STREAM) ? j_q : '0;
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == DONE);

endmodule

// File: tb/tb_tt_sampler.sv
module tb_tt_sampler;

  `define CHK(TAG, OBS, EXP) \
    begin \
      total++; \
      assert ((OBS) === (EXP)) else begin \
        bad++; \
        $error("FAIL %s observed=%0h expected=%0h", TAG, (OBS), (EXP)); \
      end \
    end

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  // A: default config, f0 = x2|x1, f1 = x0|x1
  tt_sampler_if #(.N_IN(3), .N_OUT(2)) ifa ();
  logic [2:0] xa;
  logic [1:0] fa;
  assign fa = {xa[0] | xa[1], xa[2] | xa[1]};

  tt_sampler #(.N_IN(3), .N_OUT(2), .SETTLE(1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa),
    .dut_x (xa),
    .dut_f (fa)
  );

  // B: SETTLE=3, netlist outputs arrive 2 cycles late
  tt_sampler_if #(.N_IN(3), .N_OUT(2)) ifb ();
  logic [2:0] xb;
  bit   [1:0] fb_d1, fb_d2;
  always @(posedge clk) begin
    fb_d1 <= {xb[0] | xb[1], xb[2] | xb[1]};
    fb_d2 <= fb_d1;
  end

  tt_sampler #(.N_IN(3), .N_OUT(2), .SETTLE(3)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb),
    .dut_x (xb),
    .dut_f (fb_d2)
  );

  // C: constant-0 netlist, 4 inputs, 1 output
  tt_sampler_if #(.N_IN(4), .N_OUT(1)) ifc ();
  logic [3:0] xc;
  logic [0:0] fc;
  assign fc = 1'b0;

  tt_sampler #(.N_IN(4), .N_OUT(1), .SETTLE(1)) dut_c (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc),
    .dut_x (xc),
    .dut_f (fc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wait(input string tag, input int cyc, input int limit);
    total++;
    if (cyc >= limit) begin
      bad++;
      $error("FAIL %s wait expired after %0d cycles", tag, cyc);
    end
  endtask

  initial begin
    int cyc;
    int dones;
    int words;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    ifa.start = 1'b0; ifa.tt_ready = 1'b1;
    ifb.start = 1'b0; ifb.tt_ready = 1'b1;
    ifc.start = 1'b0; ifc.tt_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    total++;
    if ((ifa.busy !== 1'b0) || (ifa.tt_valid !== 1'b0) || (ifa.done !== 1'b0) ||
        (xa !== 3'd0) || (ifa.tt_data !== 8'h00) || (ifa.tt_idx !== 1'b0)) begin
      bad++;
      $error("FAIL reset state busy=%0h valid=%0h done=%0h x=%0h data=%0h idx=%0h",
             ifa.busy, ifa.tt_valid, ifa.done, xa, ifa.tt_data, ifa.tt_idx);
    end
    `CHK("rst_busy",  ifa.busy,     1'b0)
    `CHK("rst_valid", ifa.tt_valid, 1'b0)
    `CHK("rst_done",  ifa.done,     1'b0)
    `CHK("rst_x",     xa,           3'd0)
    `CHK("rst_data",  ifa.tt_data,  8'h00)
    `CHK("rst_idx",   ifa.tt_idx,   1'b0)
    rst_n = 1'b1;

    // Basic sweep, ready always high
    @(negedge clk);
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    cyc = 1;
    `CHK("t1_busy_c1", ifa.busy, 1'b1)
    `CHK("t1_x_c1",    xa,       3'd0)
    while (!ifa.tt_valid && cyc < 200) begin
      tick();
      cyc++;
    end
    chk_wait("t1_wait", cyc, 200);
    `CHK("t1_latency", cyc,         17)
    `CHK("t1_idx0",    ifa.tt_idx,  1'b0)
    `CHK("t1_data0",   ifa.tt_data, 8'hEE)
    tick();
    `CHK("t1_valid1",  ifa.tt_valid, 1'b1)
    `CHK("t1_idx1",    ifa.tt_idx,   1'b1)
    `CHK("t1_data1",   ifa.tt_data,  8'hFC)
    tick();
    `CHK("t1_done",       ifa.done,     1'b1)
    `CHK("t1_busy_done",  ifa.busy,     1'b1)
    `CHK("t1_valid_done", ifa.tt_valid, 1'b0)
    `CHK("t1_x_done",     xa,           3'd0)
    tick();
    `CHK("t1_done_clr", ifa.done, 1'b0)
    `CHK("t1_busy_clr", ifa.busy, 1'b0)

    // Back-pressure on word 0
    @(negedge clk);
    ifa.tt_ready = 1'b0;
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    cyc = 1;
    while (!ifa.tt_valid && cyc < 200) begin
      tick();
      cyc++;
    end
    chk_wait("t2_wait", cyc, 200);
    `CHK("t2_latency", cyc, 17)
    for (int i = 0; i < 5; i++) begin
      `CHK("t2_hold_valid", ifa.tt_valid, 1'b1)
      `CHK("t2_hold_idx",   ifa.tt_idx,   1'b0)
      `CHK("t2_hold_data",  ifa.tt_data,  8'hEE)
      tick();
    end
    `CHK("t2_still_idx0", ifa.tt_idx, 1'b0)
    ifa.tt_ready = 1'b1;
    tick();
    `CHK("t2_idx1",  ifa.tt_idx,  1'b1)
    `CHK("t2_data1", ifa.tt_data, 8'hFC)
    tick();
    `CHK("t2_done", ifa.done, 1'b1)
    tick();

    // start pulses during a sweep are ignored
    @(negedge clk);
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    dones = 0;
    words = 0;
    for (cyc = 1; cyc < 40; cyc++) begin
      if (ifa.done) dones++;
      if (ifa.tt_valid && ifa.tt_ready) words++;
      ifa.start = (cyc == 3) || (cyc == 10);
      tick();
    end
    ifa.start = 1'b0;
    `CHK("t3_dones", dones, 1)
    `CHK("t3_words", words, 2)
    `CHK("t3_idle",  ifa.busy, 1'b0)

    // Reset during SAMPLE of p=4, then a clean sweep
    @(negedge clk);
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    for (cyc = 1; cyc < 10; cyc++) tick();
    `CHK("t4_x_p4", xa, 3'b001)
    rst_n = 1'b0;
    #1;
    `CHK("t4_busy",  ifa.busy,     1'b0)
    `CHK("t4_x",     xa,           3'd0)
    `CHK("t4_valid", ifa.tt_valid, 1'b0)
    `CHK("t4_done",  ifa.done,     1'b0)
    `CHK("t4_data",  ifa.tt_data,  8'h00)
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    cyc = 1;
    while (!ifa.tt_valid && cyc < 200) begin
      tick();
      cyc++;
    end
    chk_wait("t4_wait", cyc, 200);
    `CHK("t4_latency", cyc,         17)
    `CHK("t4_data0",   ifa.tt_data, 8'hEE)
    tick();
    `CHK("t4_data1",   ifa.tt_data, 8'hFC)
    tick();
    `CHK("t4_done",    ifa.done,    1'b1)

    // SETTLE=3 with delayed netlist
    @(negedge clk);
    ifb.start = 1'b1;
    tick();
    ifb.start = 1'b0;
    cyc = 1;
    while (!ifb.tt_valid && cyc < 300) begin
      tick();
      cyc++;
    end
    chk_wait("t5_wait", cyc, 300);
    `CHK("t5_latency", cyc,         33)
    `CHK("t5_idx0",    ifb.tt_idx,  1'b0)
    `CHK("t5_data0",   ifb.tt_data, 8'hEE)
    tick();
    `CHK("t5_idx1",    ifb.tt_idx,  1'b1)
    `CHK("t5_data1",   ifb.tt_data, 8'hFC)
    tick();
    `CHK("t5_done",    ifb.done,    1'b1)

    // Constant-0 netlist, single output
    @(negedge clk);
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    cyc = 1;
    while (!ifc.tt_valid && cyc < 300) begin
      tick();
      cyc++;
    end
    chk_wait("t6_wait", cyc, 300);
    `CHK("t6_latency", cyc,         33)
    `CHK("t6_idx",     ifc.tt_idx,  1'b0)
    `CHK("t6_data",    ifc.tt_data, 16'h0000)
    tick();
    `CHK("t6_done",    ifc.done,     1'b1)
    `CHK("t6_valid",   ifc.tt_valid, 1'b0)
    tick();
    `CHK("t6_idle",    ifc.busy,     1'b0)

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
